// File: rtl/strait_pkg.sv
// -----------------------------------------------------------------------------
// strait_pkg
// Shared types and constants for the STRAIT LBIST / self-repair controller.
//   state_t          : controller FSM states
//   TD_SEL_WIDTH     : width of the TD processing-element select
//   SA_PHASE_CYCLES  : cycles spent in the SA phase with default parameters
//   TD_PHASE_CYCLES  : cycles spent in the TD phase with default parameters
// -----------------------------------------------------------------------------
package strait_pkg;

  localparam int TD_SEL_WIDTH = 2;

  localparam int DEF_SYSTOLIC_SIZE = 8;
  localparam int DEF_SA_DEPTH      = 12;
  localparam int DEF_TD_DEPTH      = 16;

  // Each pattern costs one LOAD of SYSTOLIC_SIZE cycles plus one CAPT cycle.
  function automatic int phase_cycles(input int depth, input int size);
    return depth * (size + 1);
  endfunction

  localparam int SA_PHASE_CYCLES = phase_cycles(DEF_SA_DEPTH, DEF_SYSTOLIC_SIZE);
  localparam int TD_PHASE_CYCLES = phase_cycles(DEF_TD_DEPTH, DEF_SYSTOLIC_SIZE);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SA_LOAD,
    ST_SA_CAPT,
    ST_TD_LOAD,
    ST_TD_CAPT,
    ST_DLC_START,
    ST_DETECT,
    ST_ENVM_WR,
    ST_RECOV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/strait_test_controller_if.sv
// -----------------------------------------------------------------------------
// strait_test_controller_if
// Request / strobe bundle of the STRAIT test controller.
//   master : requester side (drives START, mode and BISR result inputs)
//   slave  : controller side (drives the per-cycle control strobes)
// -----------------------------------------------------------------------------
interface strait_test_controller_if
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE          = 8,
  parameter int ADDR_WIDTH             = $clog2(SYSTOLIC_SIZE),
  parameter int TD_TEST_PATTERN_DEPTH  = 16,
  parameter int MAX_PATTERN_ADDR_WIDTH = $clog2(TD_TEST_PATTERN_DEPTH)
) ();

  logic                              START;
  logic                              test_mode;
  logic                              BIST_mode;
  logic                              recovery_done;
  logic                              recovery_success;

  logic                              test_type;
  logic [MAX_PATTERN_ADDR_WIDTH-1:0] test_counter;
  logic [TD_SEL_WIDTH-1:0]           td_pe_select;
  logic                              scan_en;
  logic                              acc_wr_en;
  logic [ADDR_WIDTH-1:0]             acc_wr_addr;
  logic                              dlc_start_en;
  logic                              detection_en;
  logic                              envm_wr_en;
  logic                              weight_start;
  logic                              busy;
  logic                              done;
  logic                              repair_ok;

  modport master (
    output START, test_mode, BIST_mode, recovery_done, recovery_success,
    input  test_type, test_counter, td_pe_select, scan_en, acc_wr_en,
           acc_wr_addr, dlc_start_en, detection_en, envm_wr_en,
           weight_start, busy, done, repair_ok
  );

  modport slave (
    input  START, test_mode, BIST_mode, recovery_done, recovery_success,
    output test_type, test_counter, td_pe_select, scan_en, acc_wr_en,
           acc_wr_addr, dlc_start_en, detection_en, envm_wr_en,
           weight_start, busy, done, repair_ok
  );

endinterface

// File: rtl/strait_phase_counter.sv
// -----------------------------------------------------------------------------
// strait_phase_counter
// Loadable down-counter timing the multi-cycle LOAD and DETECT phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over en)
//   load_val   : cycles-minus-one of the phase being entered
//   en         : count down while the phase is active (holds at zero)
//   tc         : terminal count, high when the count is zero
// -----------------------------------------------------------------------------
module strait_phase_counter
  import strait_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/strait_test_controller.sv
// -----------------------------------------------------------------------------
// strait_test_controller
// LBIST and self-repair sequencer: SA patterns, TD patterns, DLC diagnosis,
// eNVM fault-map commit, then hand-over to BISR weight allocation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave modport; START/mode/recovery inputs in, strobes out
// All outputs are registered from the current state, so every strobe appears
// one cycle after the state that owns it is entered.
// -----------------------------------------------------------------------------
module strait_test_controller
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE          = 8,
  parameter int ADDR_WIDTH             = $clog2(SYSTOLIC_SIZE),
  parameter int SA_TEST_PATTERN_DEPTH  = 12,
  parameter int TD_TEST_PATTERN_DEPTH  = 16,
  parameter int MAX_PATTERN_ADDR_WIDTH = $clog2(TD_TEST_PATTERN_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  strait_test_controller_if.slave  bus
);

  localparam int MPW   = MAX_PATTERN_ADDR_WIDTH;
  localparam int CNT_W = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;

  localparam logic [MPW-1:0]   SA_LAST  = MPW'(SA_TEST_PATTERN_DEPTH - 1);
  localparam logic [MPW-1:0]   TD_LAST  = MPW'(TD_TEST_PATTERN_DEPTH - 1);
  localparam logic [MPW-1:0]   IDX_ONE  = MPW'(1);
  localparam logic [CNT_W-1:0] PH_RELD  = CNT_W'(SYSTOLIC_SIZE - 1);

  state_t         state, state_nxt;
  logic [MPW-1:0] idx, idx_nxt;
  logic           repair_q, repair_nxt;
  logic           recov_seen;
  logic           ph_load, ph_en, ph_tc;

  strait_phase_counter #(.WIDTH(CNT_W)) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (PH_RELD),
    .en       (ph_en),
    .tc       (ph_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      repair_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      repair_q <= repair_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    repair_nxt = repair_q;
    ph_load    = 1'b0;
    ph_en      = 1'b0;
    // Leaving test mode aborts from any active state; repair result is kept.
    if ((state != ST_IDLE) && !bus.test_mode) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.START && bus.test_mode && bus.BIST_mode) begin
            state_nxt  = ST_SA_LOAD;
            idx_nxt    = '0;
            repair_nxt = 1'b0;
            ph_load    = 1'b1;
          end
        end
        ST_SA_LOAD: begin
          ph_en = 1'b1;
          if (ph_tc) state_nxt = ST_SA_CAPT;
        end
        ST_SA_CAPT: begin
          ph_load = 1'b1;
          if (idx == SA_LAST) begin
            state_nxt = ST_TD_LOAD;
            idx_nxt   = '0;
          end else begin
            state_nxt = ST_SA_LOAD;
            idx_nxt   = idx + IDX_ONE;
          end
        end
        ST_TD_LOAD: begin
          ph_en = 1'b1;
          if (ph_tc) state_nxt = ST_TD_CAPT;
        end
        ST_TD_CAPT: begin
          if (idx == TD_LAST) begin
            state_nxt = ST_DLC_START;
          end else begin
            state_nxt = ST_TD_LOAD;
            idx_nxt   = idx + IDX_ONE;
            ph_load   = 1'b1;
          end
        end
        ST_DLC_START: begin
          state_nxt = ST_DETECT;
          ph_load   = 1'b1;
        end
        ST_DETECT: begin
          ph_en = 1'b1;
          if (ph_tc) state_nxt = ST_ENVM_WR;
        end
        ST_ENVM_WR: state_nxt = ST_RECOV;
        ST_RECOV: begin
          if (bus.recovery_done) begin
            state_nxt  = ST_DONE;
            repair_nxt = bus.recovery_success;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output register stage: strobes decoded from the state of the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recov_seen       <= 1'b0;
      bus.test_type    <= 1'b0;
      bus.test_counter <= '0;
      bus.td_pe_select <= '0;
      bus.scan_en      <= 1'b0;
      bus.acc_wr_en    <= 1'b0;
      bus.acc_wr_addr  <= '0;
      bus.dlc_start_en <= 1'b0;
      bus.detection_en <= 1'b0;
      bus.envm_wr_en   <= 1'b0;
      bus.weight_start <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.repair_ok    <= 1'b0;
    end else begin
      // weight_start fires only on the first RECOV cycle, however long BISR takes.
      recov_seen       <= (state == ST_RECOV);
      bus.test_type    <= (state == ST_TD_LOAD) || (state == ST_TD_CAPT);
      bus.test_counter <= idx;
      bus.td_pe_select <= ((state == ST_TD_LOAD) || (state == ST_TD_CAPT)) ?
                          idx[TD_SEL_WIDTH-1:0] : '0;
      bus.scan_en      <= (state == ST_SA_LOAD) || (state == ST_TD_LOAD);
      bus.acc_wr_en    <= (state == ST_SA_CAPT) || (state == ST_TD_CAPT);
      bus.acc_wr_addr  <= idx[ADDR_WIDTH-1:0];
      bus.dlc_start_en <= (state == ST_DLC_START);
      bus.detection_en <= (state == ST_DETECT);
      bus.envm_wr_en   <= (state == ST_ENVM_WR);
      bus.weight_start <= (state == ST_RECOV) && !recov_seen;
      bus.busy         <= (state != ST_IDLE) && (state != ST_DONE);
      bus.done         <= (state == ST_DONE);
      bus.repair_ok    <= repair_q;
    end
  end

endmodule

// File: tb/tb_strait_test_controller.sv
// -----------------------------------------------------------------------------
// tb_strait_test_controller
// Directed bench for strait_test_controller. Cycle 0 is the edge sampling
// START; outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_strait_test_controller;
  import strait_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  strait_test_controller_if bus ();

  strait_test_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {test_type, scan_en, acc_wr_en, dlc_start_en, detection_en,
  //  envm_wr_en, weight_start, busy, done}
  typedef struct {
    int         cyc;
    logic [8:0] strb;
    logic [3:0] cnt;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] strobes();
    return {bus.test_type, bus.scan_en, bus.acc_wr_en, bus.dlc_start_en,
            bus.detection_en, bus.envm_wr_en, bus.weight_start, bus.busy, bus.done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_run();
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    bus.START = 1'b0;
  endtask

  task automatic add(input int c, input logic [8:0] s, input logic [3:0] n, input logic [1:0] p);
    vec_t v;
    v.cyc = c; v.strb = s; v.cnt = n; v.sel = p;
    vecs.push_back(v);
  endtask

  initial begin
    int vi;
    int pulses;
    int exp_idx;
    bit saw_done;

    total = 0; bad = 0; cyc = 0;

    add(1,   9'b0_1_0_0_0_0_0_1_0, 4'd0,  2'd0);
    add(8,   9'b0_1_0_0_0_0_0_1_0, 4'd0,  2'd0);
    add(9,   9'b0_0_1_0_0_0_0_1_0, 4'd0,  2'd0);
    add(10,  9'b0_1_0_0_0_0_0_1_0, 4'd1,  2'd0);
    add(108, 9'b0_0_1_0_0_0_0_1_0, 4'd11, 2'd0);
    add(109, 9'b1_1_0_0_0_0_0_1_0, 4'd0,  2'd0);
    add(117, 9'b1_0_1_0_0_0_0_1_0, 4'd0,  2'd0);
    add(118, 9'b1_1_0_0_0_0_0_1_0, 4'd1,  2'd1);
    add(135, 9'b1_0_1_0_0_0_0_1_0, 4'd2,  2'd2);
    add(144, 9'b1_0_1_0_0_0_0_1_0, 4'd3,  2'd3);
    add(153, 9'b1_0_1_0_0_0_0_1_0, 4'd4,  2'd0);
    add(252, 9'b1_0_1_0_0_0_0_1_0, 4'd15, 2'd3);
    add(253, 9'b0_0_0_1_0_0_0_1_0, 4'd15, 2'd0);
    add(254, 9'b0_0_0_0_1_0_0_1_0, 4'd15, 2'd0);
    add(261, 9'b0_0_0_0_1_0_0_1_0, 4'd15, 2'd0);
    add(262, 9'b0_0_0_0_0_1_0_1_0, 4'd15, 2'd0);
    add(263, 9'b0_0_0_0_0_0_1_1_0, 4'd15, 2'd0);
    add(264, 9'b0_0_0_0_0_0_0_0_1, 4'd15, 2'd0);
    add(265, 9'b0_0_0_0_0_0_0_0_0, 4'd15, 2'd0);

    bus.START = 1'b0; bus.test_mode = 1'b1; bus.BIST_mode = 1'b1;
    bus.recovery_done = 1'b1; bus.recovery_success = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("reset_strobes", strobes(), 9'd0);
    chk("reset_counter", bus.test_counter, 4'd0);
    chk("reset_repair_ok", bus.repair_ok, 1'b0);

    // Asynchronous reset in the middle of a run.
    start_run();
    while (cyc < 50) tick();
    chk("pre_reset_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_strobes", strobes(), 9'd0);
    chk("async_reset_counter", bus.test_counter, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle", strobes(), 9'd0);

    // START ignored in MBIST mode.
    bus.BIST_mode = 1'b0;
    bus.START = 1'b1;
    repeat (10) tick();
    chk("mbist_start_ignored", strobes(), 9'd0);
    bus.START = 1'b0;
    bus.BIST_mode = 1'b1;
    tick();

    // Full run with a second START at cycle 20; checkpoint table plus capture scoreboard.
    start_run();
    vi = 0; pulses = 0;
    for (int c = 1; c <= 270; c++) begin
      if (cyc == 19) bus.START = 1'b1;
      if (cyc == 20) bus.START = 1'b0;
      tick();
      if (bus.acc_wr_en === 1'b1) begin
        exp_idx = (pulses < 12) ? pulses : pulses - 12;
        chk("capture_addr", bus.acc_wr_addr, exp_idx % 8);
        pulses++;
      end
      if (vi < vecs.size() && vecs[vi].cyc == cyc) begin
        chk("tbl_strobes", strobes(), vecs[vi].strb);
        chk("tbl_counter", bus.test_counter, vecs[vi].cnt);
        chk("tbl_pe_select", bus.td_pe_select, vecs[vi].sel);
        vi++;
      end
      if (cyc == 264) chk("repair_ok_set", bus.repair_ok, 1'b1);
    end
    chk("capture_count", pulses, 28);
    chk("table_consumed", vi, vecs.size());

    // Delayed recovery with failed repair.
    bus.recovery_done = 1'b0;
    bus.recovery_success = 1'b0;
    start_run();
    tick();
    chk("repair_ok_cleared", bus.repair_ok, 1'b0);
    while (cyc < 399) begin
      tick();
      if (cyc == 263) chk("delayed_weight_start", bus.weight_start, 1'b1);
      if (cyc == 264) chk("weight_start_single", bus.weight_start, 1'b0);
      if (cyc == 300) chk("recov_wait_busy", bus.busy, 1'b1);
    end
    bus.recovery_done = 1'b1;
    tick();
    chk("delayed_busy_400", bus.busy, 1'b1);
    chk("delayed_done_400", bus.done, 1'b0);
    bus.recovery_done = 1'b0;
    tick();
    chk("delayed_done_401", bus.done, 1'b1);
    chk("delayed_busy_401", bus.busy, 1'b0);
    chk("delayed_repair_fail", bus.repair_ok, 1'b0);
    repeat (10) tick();
    chk("idle_after_delayed", strobes(), 9'd0);
    chk("repair_ok_held", bus.repair_ok, 1'b0);

    // START held high across DONE restarts from IDLE.
    bus.recovery_done = 1'b1;
    bus.recovery_success = 1'b1;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    while (cyc < 266) begin
      tick();
      if (cyc == 264) chk("hold_done", bus.done, 1'b1);
      if (cyc == 265) begin
        chk("hold_idle_gap", bus.busy, 1'b0);
        chk("hold_repair_ok", bus.repair_ok, 1'b1);
      end
    end
    chk("restart_busy", bus.busy, 1'b1);
    chk("restart_scan", bus.scan_en, 1'b1);
    chk("restart_repair_clr", bus.repair_ok, 1'b0);
    bus.START = 1'b0;
    bus.test_mode = 1'b0;
    repeat (3) tick();
    bus.test_mode = 1'b1;
    tick();

    // Abort by dropping test_mode at cycle 150.
    start_run();
    while (cyc < 149) tick();
    bus.test_mode = 1'b0;
    tick();
    chk("abort_busy_150", bus.busy, 1'b1);
    chk("abort_scan_150", bus.scan_en, 1'b1);
    tick();
    chk("abort_strobes_151", strobes(), 9'd0);
    saw_done = 1'b0;
    bus.test_mode = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 1'b0);
    chk("abort_repair_kept", bus.repair_ok, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
